// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter with locked bursts and a bounded hold count.
// Define RAM_ARB_RR_EN for round-robin contention; default is port 0 priority.
module ram_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int HOLD_MAX = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [3:0] HMAX = 4'(HOLD_MAX);

   logic          r_last;
   logic [3:0]    r_hold_cnt;
   logic          r_rv0;
   logic          r_rv1;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   logic          w_req_l;
   logic          w_lock_l;
   logic          w_req_o;
   logic          w_any;
   logic          w_sel;
   logic          w_we;
   logic          w_lock;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [3:0]    w_hold_nxt;

   // Arbitration: lock continuation, forced yield, contention, single.
   always_comb begin
      w_req_l  = r_last ? m1_req  : m0_req;
      w_lock_l = r_last ? m1_lock : m0_lock;
      w_req_o  = r_last ? m0_req  : m1_req;
      w_any    = 1'b0;
      w_sel    = r_last;
      if (reset_n) begin
         if (w_req_l && w_lock_l) begin
            w_any = 1'b1;
            w_sel = (r_hold_cnt >= HMAX && w_req_o) ? ~r_last : r_last;
         end else if (m0_req && m1_req) begin
            w_any = 1'b1;
`ifdef RAM_ARB_RR_EN
            w_sel = ~r_last;
`else
            w_sel = 1'b0;
`endif
         end else if (m0_req || m1_req) begin
            w_any = 1'b1;
            w_sel = m1_req;
         end
      end
   end

   always_comb begin
      w_we    = w_sel ? m1_we    : m0_we;
      w_lock  = w_sel ? m1_lock  : m0_lock;
      w_addr  = w_sel ? m1_addr  : m0_addr;
      w_wdata = w_sel ? m1_wdata : m0_wdata;
   end

   always_comb begin
      w_hold_nxt = 4'd0;
      if (w_any) begin
         if (w_sel != r_last || !w_lock)
            w_hold_nxt = 4'd1;
         else if (r_hold_cnt < HMAX)
            w_hold_nxt = r_hold_cnt + 4'd1;
         else
            w_hold_nxt = HMAX;
      end
   end

   assign m0_gnt    = w_any & ~w_sel;
   assign m1_gnt    = w_any & w_sel;
   assign ram_addr  = w_any ? w_addr  : r_addr;
   assign ram_wdata = w_any ? w_wdata : r_wdata;
   assign ram_we    = w_any & w_we;

   // Gated by reset so a read issued just before reset never surfaces.
   assign m0_rvalid = r_rv0 & reset_n;
   assign m1_rvalid = r_rv1 & reset_n;
   assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
   assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last     <= 1'b1;
         r_hold_cnt <= 4'd0;
         r_rv0      <= 1'b0;
         r_rv1      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_rv0      <= m0_gnt & ~m0_we;
         r_rv1      <= m1_gnt & ~m1_we;
         r_hold_cnt <= w_hold_nxt;
         if (w_any) begin
            r_last  <= w_sel;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a write-first registered RAM model.
// Expected contention order follows RAM_ARB_RR_EN.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_req, m0_we, m0_lock;
   logic [7:0]  m0_addr;
   logic [15:0] m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [15:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [7:0]  m1_addr;
   logic [15:0] m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [15:0] m1_rdata;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   logic [15:0] mem [256];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.AW(8), .DW(16), .HOLD_MAX(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_lock   (m0_lock),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic       cont_g0 [4];
   logic       lk_m0req [7];
   logic       lk_g1 [7];
   logic [3:0] lk_hold [7];
   logic [3:0] la_hold [10];

   initial begin
`ifdef RAM_ARB_RR_EN
      cont_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      cont_g0 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      lk_m0req = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      lk_g1    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      lk_hold  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd1};
      la_hold  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                   4'd4, 4'd4, 4'd4, 4'd4, 4'd4};

      reset_n  = 1'b0;
      m0_req   = 1'b1; m0_we = 1'b0; m0_lock = 1'b0;
      m0_addr  = 8'h10; m0_wdata = 16'h0;
      m1_req   = 1'b1; m1_we = 1'b0; m1_lock = 1'b0;
      m1_addr  = 8'h20; m1_wdata = 16'h0;

      // reset held with both requesting
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_g0", m0_gnt, 0);
         check("rst_g1", m1_gnt, 0);
         check("rst_rv0", m0_rvalid, 0);
         check("rst_rv1", m1_rvalid, 0);
         check("rst_we", ram_we, 0);
      end
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_rdata0", m0_rdata, 0);
      check("rst_last", dut.r_last, 1);
      check("rst_hold", dut.r_hold_cnt, 0);
      tick();
      reset_n = 1'b1;

      // unlocked contention
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("cont_g0", m0_gnt, cont_g0[i]);
         check("cont_g1", m1_gnt, !cont_g0[i]);
         tick();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      check("idle_g0", m0_gnt, 0);
      check("idle_g1", m1_gnt, 0);
      check("idle_we", ram_we, 0);
`ifdef RAM_ARB_RR_EN
      check("idle_addr", ram_addr, 8'h20);
`else
      check("idle_addr", ram_addr, 8'h10);
`endif
      tick();

      // write via port 1 then read via port 0
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h05; m1_wdata = 16'h1234;
      @(negedge clk);
      check("wr_g1", m1_gnt, 1);
      check("wr_we", ram_we, 1);
      check("wr_addr", ram_addr, 8'h05);
      check("wr_data", ram_wdata, 16'h1234);
      tick();
      m1_req = 1'b0; m1_we = 1'b0;
      m0_req = 1'b1; m0_addr = 8'h05;
      @(negedge clk);
      check("rd_g0", m0_gnt, 1);
      check("rd_rv0_early", m0_rvalid, 0);
      check("wr_no_rv1", m1_rvalid, 0);
      tick();
      m0_req = 1'b0;
      @(negedge clk);
      check("rd_rv0", m0_rvalid, 1);
      check("rd_data", m0_rdata, 16'h1234);
      check("rd_rv1", m1_rvalid, 0);
      tick();
      @(negedge clk);
      check("rd_rv0_once", m0_rvalid, 0);
      tick();

      // port 1 locked burst against port 0
      m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h05;
      m0_addr = 8'h06;
      for (int i = 0; i < 7; i++) begin
         m0_req = lk_m0req[i];
         @(negedge clk);
         check("lk_g1", m1_gnt, lk_g1[i]);
         check("lk_g0", m0_gnt, lk_m0req[i] && !lk_g1[i]);
         check("lk_hold", dut.r_hold_cnt, lk_hold[i]);
         tick();
      end
      m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
      @(negedge clk);
      check("lk_idle", m0_gnt | m1_gnt, 0);
      tick();

      // port 0 locked alone
      m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 8'h07;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("la_g0", m0_gnt, 1);
         check("la_hold", dut.r_hold_cnt, la_hold[i]);
         tick();
      end
      m0_req = 1'b0; m0_lock = 1'b0;
      @(negedge clk);
      check("la_sat", dut.r_hold_cnt, 4);
      tick();
      @(negedge clk);
      check("la_clr", dut.r_hold_cnt, 0);
      tick();

      // reset in the cycle after a granted read
      m0_req = 1'b1; m0_addr = 8'h05;
      @(negedge clk);
      check("mr_g0", m0_gnt, 1);
      tick();
      reset_n = 1'b0; m0_req = 1'b0;
      @(negedge clk);
      check("mr_rv0_a", m0_rvalid, 0);
      tick();
      @(negedge clk);
      check("mr_rv0_b", m0_rvalid, 0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check("mr_rv0_c", m0_rvalid, 0);
      check("mr_last", dut.r_last, 1);
      tick();
      @(negedge clk);
      check("mr_rv0_d", m0_rvalid, 0);
      check("mr_rv1_d", m1_rvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the computer's single-port `ram` between the CPU memory port (port 0) and the program loader/debug port (port 1). It issues at most one RAM access per clock and returns read data one cycle later. It supports locked bursts with a bounded hold count. It sits between the CPU/loader and `ram` inside `computer`.

## Interface
Parameters:
- `AW`, 8: address width; matches `ram` depth.
- `DW`, 16: data width.
- `HOLD_MAX`, 4: maximum consecutive locked grants before a forced yield; range 1–15.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `m0_req` in 1: port 0 request.
- `m0_we` in 1: port 0 write enable.
- `m0_lock` in 1: port 0 burst lock.
- `m0_addr` in AW: port 0 address.
- `m0_wdata` in DW: port 0 write data.
- `m0_gnt` out 1: port 0 grant; the transfer is issued this cycle.
- `m0_rvalid` out 1: port 0 read data valid.
- `m0_rdata` out DW: port 0 read data.
- `m1_*`: identical set for port 1.
- `ram_addr` out AW: RAM address.
- `ram_we` out 1: RAM write strobe.
- `ram_wdata` out DW: RAM write data.
- `ram_rdata` in DW: RAM read data, registered by `ram`, valid 1 cycle after address.

## Operation
- Handshake:
  - A transfer is issued in a cycle with `mX_req & mX_gnt`.
  - The requester holds `we/addr/wdata/lock` stable until granted.
  - `req` may drop at any time before grant with no effect.
- Grants:
  - `mX_gnt` is combinational from the requests and registered state.
  - At most one `gnt` is high per cycle.
  - No grant is given without `req`.
- RAM mux: the granted port drives `ram_addr/ram_we/ram_wdata`.
  - With no grant, `ram_we=0` and `ram_addr` holds its last value.
- Reads: `mX_rvalid` is pulsed exactly 1 cycle after a granted read, with `mX_rdata = ram_rdata`. Writes produce no `rvalid`.
- Registered state: `last` (last granted port, 1 bit); `hold_cnt` (4 bits, consecutive grants to `last` while locked).
- Arbitration order (priority high→low):
  1. Lock continuation: `last` requests with `lock=1` and `hold_cnt < HOLD_MAX` → grant `last`. `hold_cnt` increments.
  2. Forced yield: `last` locked but `hold_cnt == HOLD_MAX` and the other port requests → grant the other port. `hold_cnt` resets to 1.
     - If the other port is idle, `last` continues and `hold_cnt` saturates at `HOLD_MAX`.
  3. Contention without lock: selected per the Configuration section.
  4. Single requester: that port is granted.
- `hold_cnt` bookkeeping:
  - Set to 1 on any grant that changes `last`, or on a grant with `lock=0`.
  - Cleared to 0 on any idle cycle.
- Lock semantics: `lock` is sampled with the granted transfer. Dropping `lock` ends the burst at the next arbitration.

## Timing
- Reset values: `m0_gnt=m1_gnt=0`, `m0_rvalid=m1_rvalid=0`, `mX_rdata=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `last=1`, `hold_cnt=0`.
- Grants are forced to 0 while `reset_n=0`.
- Grant latency: 0 cycles from `req` when uncontended.
- Read latency: 1 cycle from grant to `rvalid`.
- Throughput: 1 transfer per cycle, with back-to-back grants to the same or alternating ports.
- Reset mid-operation: a pending `rvalid` is dropped; it must not appear after reset is released.
- Write-then-read of the same address on consecutive cycles by either port returns the new data; this is RAM write-first behaviour, and the arbiter adds no hazard logic.

## Configuration
- `RAM_ARB_RR_EN`, defined: contention without lock grants the port ≠ `last` (round-robin). Since `last` resets to 1, port 0 wins the first contention.
- `RAM_ARB_RR_EN`, undefined: contention without lock always grants port 0 (fixed priority). The lock and forced-yield rules are unchanged, so port 1 can still be starved only by unlocked port 0 traffic.

## Test plan
- Reset: hold `reset_n=0` for 3 cycles with both `req=1` → all `gnt`, `rvalid`, and `ram_we` stay 0; on release, port 0 is granted first.
- Single read: write 0x1234 to addr 5 via port 1, then read addr 5 via port 0 → `m0_rvalid` is high exactly 1 cycle after grant, with `m0_rdata=0x1234` and `m1_rvalid=0`.
- Contention (RR_EN defined): both ports request continuous unlocked reads → grant sequence 0,1,0,1. With RR_EN undefined → 0,0,0,0.
- Lock with HOLD_MAX=4: port 1 locks and requests continuously while port 0 requests → port 1 gets 4 grants, then port 0 gets 1, then port 1 resumes with `hold_cnt=1`.
- Lock alone: port 0 locks for 10 cycles with port 1 idle → 10 consecutive port 0 grants, with `hold_cnt` saturating at 4.
- Reset mid-read: assert `reset_n=0` in the cycle after a granted read → `rvalid` stays 0 throughout and after reset.
